// File: rtl/tblink_call_initiator.sv
// Call initiator: allocates call slots to user commands, issues them through a
// single request register, and reports response, timeout or unknown-id completions.
module tblink_call_initiator #(
  parameter int NSLOTS  = 4,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            reset_n,

  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [7:0]      cmd_method,
  input  logic [31:0]     cmd_arg,

  output logic            req_valid,
  input  logic            req_ready,
  output logic [ID_W-1:0] req_id,
  output logic [7:0]      req_method,
  output logic [31:0]     req_arg,

  input  logic            rsp_valid,
  input  logic [ID_W-1:0] rsp_id,
  input  logic [31:0]     rsp_rv,

  output logic            cpl_valid,
  output logic [ID_W-1:0] cpl_id,
  output logic [31:0]     cpl_rv,
  output logic [1:0]      cpl_status,

  output logic [ID_W:0]   outstanding,
  output logic            busy
);

  localparam int               TMR_W   = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_PRE = TMR_W'(TIMEOUT - 2);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_UNKNOWN = 2'b10;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_QUEUED,
    SLOT_ISSUED
  } slot_state_t;

  logic [NSLOTS-1:0] free_vec;
  logic [NSLOTS-1:0] issued_vec;
  logic [NSLOTS-1:0] expired_vec;
  logic [NSLOTS-1:0] rsp_hit_vec;
  logic [NSLOTS-1:0] alloc_vec;
  logic [NSLOTS-1:0] to_sel_vec;

  logic            req_valid_reg;
  logic [ID_W-1:0] req_id_reg;
  logic [7:0]      req_method_reg;
  logic [31:0]     req_arg_reg;

  logic            cpl_valid_reg;
  logic [ID_W-1:0] cpl_id_reg;
  logic [31:0]     cpl_rv_reg;
  logic [1:0]      cpl_status_reg;

  logic            req_hs;
  logic            cmd_fire;
  logic            rsp_hit;
  logic            to_any;
  logic [ID_W-1:0] alloc_idx;
  logic [ID_W-1:0] to_idx;
  logic [ID_W:0]   outstanding_cnt;

  assign req_hs    = req_valid_reg & req_ready;
  assign cmd_ready = reset_n & (|free_vec) & (~req_valid_reg | req_ready);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_hit   = |rsp_hit_vec;

  // Any response (even an unknown id) owns the completion port; timeouts wait.
  assign to_any     = ~rsp_valid & (|expired_vec);
  assign alloc_vec  = free_vec & (~free_vec + NSLOTS'(1));
  assign to_sel_vec = to_any ? (expired_vec & (~expired_vec + NSLOTS'(1))) : '0;

  always_comb begin
    alloc_idx = '0;
    to_idx    = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = ID_W'(i);
      if (expired_vec[i]) to_idx = ID_W'(i);
    end
  end

  always_comb begin
    outstanding_cnt = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (!free_vec[i]) outstanding_cnt = outstanding_cnt + (ID_W+1)'(1);
    end
  end

  assign outstanding = outstanding_cnt;
  assign busy        = (outstanding_cnt != '0);

  generate
    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
      slot_state_t      state_reg;
      logic [TMR_W-1:0] timer_reg;
      logic             hs_here;

      assign hs_here          = req_hs && (req_id_reg == ID_W'(gi));
      assign free_vec[gi]     = (state_reg == SLOT_FREE);
      assign issued_vec[gi]   = (state_reg == SLOT_ISSUED);
      // Fires on the edge where the timer reaches TIMEOUT-1, and stays up while saturated.
      assign expired_vec[gi]  = issued_vec[gi] && ((timer_reg == TMR_PRE) || (timer_reg == TMR_MAX));
      assign rsp_hit_vec[gi]  = rsp_valid && (rsp_id == ID_W'(gi)) && issued_vec[gi];

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          state_reg <= SLOT_FREE;
          timer_reg <= '0;
        end else begin
          case (state_reg)
            SLOT_FREE: begin
              if (cmd_fire && alloc_vec[gi]) state_reg <= SLOT_QUEUED;
            end
            SLOT_QUEUED: begin
              if (hs_here) begin
                state_reg <= SLOT_ISSUED;
                timer_reg <= '0;
              end
            end
            SLOT_ISSUED: begin
              if (rsp_hit_vec[gi] || to_sel_vec[gi]) begin
                state_reg <= SLOT_FREE;
                timer_reg <= '0;
              end else if (timer_reg != TMR_MAX) begin
                timer_reg <= timer_reg + TMR_W'(1);
              end
            end
            default: begin
              state_reg <= SLOT_FREE;
              timer_reg <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_valid_reg  <= 1'b0;
      req_id_reg     <= '0;
      req_method_reg <= '0;
      req_arg_reg    <= '0;
      cpl_valid_reg  <= 1'b0;
      cpl_id_reg     <= '0;
      cpl_rv_reg     <= '0;
      cpl_status_reg <= '0;
    end else begin
      // A new command may reload the register in the same cycle it handshakes.
      if (cmd_fire) begin
        req_valid_reg  <= 1'b1;
        req_id_reg     <= alloc_idx;
        req_method_reg <= cmd_method;
        req_arg_reg    <= cmd_arg;
      end else if (req_hs) begin
        req_valid_reg  <= 1'b0;
      end

      cpl_valid_reg <= rsp_valid | to_any;
      if (rsp_valid) begin
        cpl_id_reg     <= rsp_id;
        cpl_rv_reg     <= rsp_rv;
        cpl_status_reg <= rsp_hit ? ST_OK : ST_UNKNOWN;
      end else if (to_any) begin
        cpl_id_reg     <= to_idx;
        cpl_rv_reg     <= '0;
        cpl_status_reg <= ST_TIMEOUT;
      end
    end
  end

  assign req_valid  = req_valid_reg;
  assign req_id     = req_id_reg;
  assign req_method = req_method_reg;
  assign req_arg    = req_arg_reg;
  assign cpl_valid  = cpl_valid_reg;
  assign cpl_id     = cpl_id_reg;
  assign cpl_rv     = cpl_rv_reg;
  assign cpl_status = cpl_status_reg;

endmodule

// File: doc/tblink_call_initiator.md
TBLINK_CALL_INITIATOR -- requirements
Module: tblink_call_initiator

Interface
REQ-001 Parameters SHALL be: NSLOTS, default 4, number of outstanding-call slots (2..16).
REQ-002 Parameters SHALL include: ID_W, default 4, call-id width, with 2**ID_W >= NSLOTS.
REQ-003 Parameters SHALL include: TIMEOUT, default 1024, cycles from request issue to timeout (>= 2).
REQ-004 Port: clock  in  1  sole clock; all logic on posedge clock.
REQ-005 Port: reset_n  in  1  synchronous, active-low reset.
REQ-006 Ports: cmd_valid in 1, cmd_ready out 1, cmd_method in 8, cmd_arg in 32  user call request.
REQ-007 Ports: req_valid out 1, req_ready in 1, req_id out ID_W, req_method out 8, req_arg out 32  call issued toward target.
REQ-008 Ports: rsp_valid in 1, rsp_id in ID_W, rsp_rv in 32  target completion (no backpressure).
REQ-009 Ports: cpl_valid out 1, cpl_id out ID_W, cpl_rv out 32, cpl_status out 2  completion to user (00 ok, 01 timeout, 10 unknown id).
REQ-010 Ports: outstanding out ID_W+1  count of non-FREE slots; busy out 1  outstanding != 0.

Function
REQ-011 Each slot SHALL be in one of FREE, QUEUED (in request register, not yet accepted by target), ISSUED (accepted, awaiting response).
REQ-012 cmd_ready SHALL be 1 when at least one slot is FREE and the request register is empty or handshaking (req_valid & req_ready) this cycle.
REQ-013 On cmd_valid & cmd_ready, the lowest-index FREE slot SHALL go FREE->QUEUED and the request register SHALL load id=slot index, method, arg, with req_valid=1 the next cycle.
REQ-014 req_valid/req_id/req_method/req_arg SHALL hold stable until req_ready is sampled 1; then slot QUEUED->ISSUED and its timer SHALL clear to 0.
REQ-015 Back-to-back issue SHALL be supported: a command accepted in the same cycle as a request handshake SHALL present next cycle with no bubble.
REQ-016 Each ISSUED slot's timer SHALL increment once per cycle; on reaching TIMEOUT-1 the slot SHALL raise a timeout event.
REQ-017 rsp_valid with rsp_id naming an ISSUED slot SHALL produce cpl_valid=1, cpl_id=rsp_id, cpl_rv=rsp_rv, cpl_status=00 the next cycle and free that slot.
REQ-018 rsp_valid with rsp_id naming a FREE or QUEUED slot, or >= NSLOTS, SHALL produce cpl_status=10, cpl_rv=rsp_rv, cpl_id=rsp_id next cycle, with no slot change.
REQ-019 A timeout event SHALL produce cpl_status=01, cpl_rv=0, cpl_id=slot and free the slot; a later response for that id follows REQ-018.
REQ-020 cpl_valid SHALL be a one-cycle pulse; at most one completion per cycle.
REQ-021 Arbitration: response completion SHALL beat timeout; pending timeouts SHALL be held (timer saturated) and reported lowest-index first in later cycles.
REQ-022 Response and timeout for the same slot in the same cycle SHALL yield status 00 only.
REQ-023 A slot freed in cycle N SHALL be allocatable by a command in cycle N+1, not N.
REQ-024 outstanding SHALL reflect slot states registered at end of previous cycle.

Reset
REQ-025 When reset_n=0 at a clock edge: all slots FREE, timers 0, request register empty.
REQ-026 Reset outputs: req_valid=0, cpl_valid=0, cmd_ready=0 during reset, req_id/req_method/req_arg/cpl_id/cpl_rv/cpl_status=0, outstanding=0, busy=0.
REQ-027 Reset mid-operation SHALL discard all in-flight calls silently (no completions); responses arriving after reset release SHALL be reported per REQ-018.
REQ-028 cmd_ready SHALL go 1 the first cycle after reset_n returns high.

Verification
REQ-029 Single call: cmd method=0 arg=5, req_ready=1, rsp id=0 rv=6 two cycles later -> req_id=0 one cycle after accept, cpl id=0 rv=6 status=00, outstanding back to 0.
REQ-030 Fill: 5 commands, req_ready=1, no responses -> ids 0,1,2,3 issued, cmd_ready=0 with 5th pending, outstanding=4; rsp id=2 -> 5th issues with id=2.
REQ-031 Backpressure: req_ready=0 for 10 cycles -> req_valid=1, req_id/method/arg stable, no timeout (slot QUEUED); req_ready=1 -> issue.
REQ-032 Timeout: TIMEOUT=16, call issued, no response -> cpl status=01 exactly 16 cycles after issue handshake; later rsp with same id -> status=10.
REQ-033 Collision: slots 0 and 1 time out same cycle while rsp id=3 valid -> cpl id=3 status=00, then id=0 status=01, then id=1 status=01 in consecutive cycles.
REQ-034 Reset: reset_n=0 with 3 slots ISSUED -> no cpl_valid, outstanding=0, busy=0 after reset; rsp id=1 afterwards -> status=10.
